// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry IF/ID instruction queue with valid/ready on both sides,
// synchronous flush for redirects, and NOP-padded show-ahead output when empty.
module if_id_queue #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [ILEN-1:0] NOP_INSN = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            pc_in,
    input  logic [ILEN-1:0]            instruction_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            pc_out,
    output logic [ILEN-1:0]            instruction_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] r_pc   [DEPTH];
    logic [ILEN-1:0] r_insn [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count;
    logic            w_push, w_pop;

    // Occupancy alone decides full/empty, so in_ready never depends on out_ready.
    assign in_ready        = r_count != CW'(DEPTH);
    assign out_valid       = r_count != '0;
    assign w_push          = in_valid && in_ready;
    assign w_pop           = out_valid && out_ready;
    assign pc_out          = out_valid ? r_pc[r_rd] : '0;
    assign instruction_out = out_valid ? r_insn[r_rd] : NOP_INSN;
    assign count           = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_insn[i] <= NOP_INSN;
            end
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wr]   <= pc_in;
                r_insn[r_wr] <= instruction_in;
                r_wr         <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and randomized checks of if_id_queue against a
// queue-based reference model of the fetch/decode handshake.
module tb_if_id_queue;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int VW = 1 + 1 + 3 + XLEN + ILEN;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] pc_in = '0;
    logic [ILEN-1:0] instruction_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] pc_out;
    logic [ILEN-1:0] instruction_out;
    logic [2:0]      count;

    int checks = 0;
    int failures = 0;

    logic [XLEN+ILEN-1:0] model[$];
    logic [VW-1:0] got;
    logic [VW-1:0] rst_vec;

    assign got     = {out_valid, in_ready, count, pc_out, instruction_out};
    assign rst_vec = {1'b0, 1'b1, 3'd0, 32'd0, NOP};

    if_id_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instruction_out(instruction_out),
        .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (count > 3'(DEPTH)) begin
                failures++;
                $display("FAIL count_bound got=%0d max=%0d", count, DEPTH);
            end
        end
    end

    function automatic logic [VW-1:0] exp_vec();
        if (model.size() == 0) return {1'b0, 1'b1, 3'd0, 32'd0, NOP};
        return {1'b1, model.size() != DEPTH, 3'(model.size()), model[0]};
    endfunction

    // Reference: decide push/pop from the pre-edge occupancy, flush discards everything.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        bit do_push, do_pop;
        in_valid = iv; pc_in = pc; instruction_in = ins; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (flush) model.delete();
        else begin
            do_push = in_valid && model.size() != DEPTH;
            do_pop  = out_ready && model.size() != 0;
            if (do_pop) void'(model.pop_front());
            if (do_push) model.push_back({pc_in, instruction_in});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (got !== rst_vec) begin failures++; $display("FAIL reset_during got=%h exp=%h", got, rst_vec); end
        @(posedge clk); #1;
        rst = 1'b0;
        model.delete();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (got !== rst_vec) begin failures++; $display("FAIL reset_idle got=%h exp=%h", got, rst_vec); end
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'(i * 4), 32'h00500093 + 32'(i << 20), 1'b0, 1'b0);
            checks++;
            if (got !== exp_vec()) begin failures++; $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp_vec()); end
        end
        checks++;
        if ({count, in_ready, pc_out} !== {3'd4, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL fill_full got=%0d/%b/%h exp=4/0/00000000", count, in_ready, pc_out);
        end
    endtask

    task automatic test_drain();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_out !== 32'(i * 4)) begin failures++; $display("FAIL drain_pc[%0d] got=%h exp=%h", i, pc_out, 32'(i * 4)); end
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (got !== exp_vec()) begin failures++; $display("FAIL drain[%0d] got=%h exp=%h", i, got, exp_vec()); end
        end
        checks++;
        if ({count, instruction_out} !== {3'd0, NOP}) begin
            failures++;
            $display("FAIL drain_empty got=%0d/%h exp=0/%h", count, instruction_out, NOP);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h100, 32'h11100093, 1'b0, 1'b0);
        step(1'b1, 32'h104, 32'h11200093, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h108 + 32'(i * 4), 32'h22000093 + 32'(i), 1'b1, 1'b0);
            checks++;
            if (count !== 3'd2 || got !== exp_vec()) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp_vec());
            end
        end
        checks++;
        if (pc_out !== 32'h128) begin failures++; $display("FAIL b2b_order got=%h exp=00000128", pc_out); end
    endtask

    task automatic test_flush();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(i * 4), 32'h33000093 + 32'(i), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3) begin failures++; $display("FAIL flush_pre got=%0d exp=3", count); end
        step(1'b1, 32'h40, 32'h44400093, 1'b1, 1'b1);
        checks++;
        if (got !== rst_vec) begin failures++; $display("FAIL flush got=%h exp=%h", got, rst_vec); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b0 || pc_out === 32'h40) begin
                failures++;
                $display("FAIL flush_ghost got=%b/%h exp=0/00000000", out_valid, pc_out);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h300, 32'h55500093, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'h55600093, 1'b0, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd2) begin failures++; $display("FAIL areset_pre got=%0d exp=2", count); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (got !== rst_vec) begin failures++; $display("FAIL areset got=%h exp=%h", got, rst_vec); end
        #1 rst = 1'b0;
        model.delete();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (got !== rst_vec) begin failures++; $display("FAIL areset_after got=%h exp=%h", got, rst_vec); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), $urandom_range(0, 31) == 0);
            checks++;
            if (got !== exp_vec()) begin failures++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry instruction queue between fetch and decode; lets fetch run ahead of decode stalls.
- Valid/ready handshake on both sides, synchronous flush for branch/jump redirect, and a NOP-padded output when empty.
- Sits between the IF stage (PC + instruction memory) and the ID stage/hazard unit.

Parameters:
- XLEN, 32, width of the PC field.
- ILEN, 32, width of the instruction field.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- NOP_INSN, 32'h00000013, instruction presented when the queue is empty or after reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous discard of all entries (branch/jump redirect).
- in_valid  in  1  fetch presents pc_in/instruction_in.
- in_ready  out  1  queue can accept an entry this cycle.
- pc_in  in  XLEN  PC of the fetched instruction.
- instruction_in  in  ILEN  fetched instruction.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  decode consumes the head this cycle; low means stall.
- pc_out  out  XLEN  PC of the head entry.
- instruction_out  out  ILEN  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=1, async):
  - write pointer, read pointer and count are cleared to 0.
  - all storage entries are cleared to pc=0, instruction=NOP_INSN.
  - Outputs during and after reset: out_valid=0, in_ready=1, pc_out=0, instruction_out=NOP_INSN, count=0.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr advances by 1 modulo DEPTH.
- in_ready = (count != DEPTH). It is registered-state only, with no combinational path from out_ready. A full queue does not accept data in the same cycle it pops.
- out_valid = (count != 0).
- Output data is show-ahead (first-word fall-through from storage):
  - When count != 0: pc_out/instruction_out reflect entry[rd_ptr] combinationally from state.
  - When count == 0: pc_out=0 and instruction_out=NOP_INSN.
- Latency: an entry pushed at edge N is visible on the outputs (out_valid=1) after edge N. There is no same-cycle bypass from input to output.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged (legal when 0<count<DEPTH).
- Flush (synchronous, highest priority below rst):
  - at the next edge, pointers and count become 0.
  - any push or pop in the flush cycle is discarded.
  - storage contents are not required to be cleared, but outputs must read 0/NOP_INSN because count=0.
- Stall: when out_ready=0, head and outputs hold stable. Fetch may keep pushing until full, then in_ready=0 back-pressures fetch.
- Pointer wrap: rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full/empty is derived from count, not from pointer equality.
- Illegal conditions:
  - pop when empty is impossible, because out_valid gates it.
  - push when full is ignored, because in_ready gates it.
  - A bench assertion must never see count > DEPTH.
- Reset mid-operation: asynchronous clear takes effect immediately, regardless of any in-flight push or pop.

Test Plan:
- Reset then idle: assert rst, release, hold in_valid=0 -> out_valid=0, in_ready=1, pc_out=0, instruction_out=32'h00000013, count=0.
- Fill to full with out_ready=0: push pc 0x00,0x04,0x08,0x0C with instructions 0x00500093..0x00800093 -> count=4, in_ready=0, pc_out=0x00; a fifth push (pc 0x10) is ignored.
- Drain in order: from full, out_ready=1 for 4 cycles -> pc_out sequence 0x00,0x04,0x08,0x0C, then count=0 and instruction_out=NOP.
- Simultaneous push/pop plus wrap: with count=2, run push+pop for 10 cycles -> count stays 2, PCs emerge strictly in order across the pointer wrap (DEPTH=4).
- Flush with concurrent push: count=3, assert flush with in_valid=1 pc=0x40 -> next cycle count=0, out_valid=0, instruction_out=NOP; the 0x40 entry never appears.
- Async reset mid-stream: count=2, pulse rst between edges -> outputs go to 0/NOP and count=0 immediately, without waiting for a clock edge.
